// File: rtl/seg_scan_decoder.sv
// Recovers 16-bit frames from an active-low multiplexed 4-digit seven-segment scan bus.
// Latency: digit captured STABLE_CYCLES edges after it appears; frame valid one edge after the 4th capture.
module seg_scan_decoder #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [7:0]  i_seg_in,
    input  logic [3:0]  i_dig_sel,
    output logic [15:0] o_value,
    output logic        o_frame_err,
    output logic        o_frame_valid,
    input  logic        i_frame_ready
);

    localparam logic [7:0] LP_STABLE = 8'(STABLE_CYCLES);

    typedef enum logic {ST_COLLECT, ST_HOLD} state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [7:0]  r_seg_q;
    logic [3:0]  r_sel_q;
    logic [7:0]  r_cnt;
    logic [7:0]  w_cnt_next;
    logic        r_cap;
    logic        w_cap_next;
    logic        w_onehot;
    logic        w_changed;
    logic        w_launch;
    logic [15:0] r_digit;
    logic [15:0] w_digit_next;
    logic [3:0]  r_captured;
    logic [3:0]  w_captured_next;
    logic        r_err_acc;
    logic        w_err_acc_next;
    logic [4:0]  w_dec;

    function automatic logic [4:0] decode(input logic [7:0] seg);
        case (seg)
            8'hC0:   decode = 5'h00;
            8'hF9:   decode = 5'h01;
            8'hA4:   decode = 5'h02;
            8'hB0:   decode = 5'h03;
            8'h99:   decode = 5'h04;
            8'h92:   decode = 5'h05;
            8'h82:   decode = 5'h06;
            8'hF8:   decode = 5'h07;
            8'h80:   decode = 5'h08;
            8'h90:   decode = 5'h09;
            8'h88:   decode = 5'h0A;
            8'h83:   decode = 5'h0B;
            8'hC6:   decode = 5'h0C;
            8'hA1:   decode = 5'h0D;
            8'h86:   decode = 5'h0E;
            8'h8E:   decode = 5'h0F;
            default: decode = 5'h10;
        endcase
    endfunction

    // The counter looks at the pins being registered this edge, so a pattern present
    // before edge 0 reads as count 1 after edge 0 and captures at edge STABLE_CYCLES.
    always_comb begin
        w_onehot   = (i_dig_sel == 4'b1110) || (i_dig_sel == 4'b1101) ||
                     (i_dig_sel == 4'b1011) || (i_dig_sel == 4'b0111);
        w_changed  = {i_seg_in, i_dig_sel} != {r_seg_q, r_sel_q};
        w_cnt_next = r_cnt;
        if (!w_onehot)
            w_cnt_next = 8'd0;
        else if (w_changed)
            w_cnt_next = 8'd1;
        else if (r_cnt != LP_STABLE)
            w_cnt_next = r_cnt + 8'd1;
        w_cap_next = (w_cnt_next == LP_STABLE) &&
                     ((w_onehot && w_changed) || (r_cnt != LP_STABLE));
    end

    always_comb begin
        w_state_next = r_state;
        w_launch     = 1'b0;
        case (r_state)
            ST_COLLECT: begin
                if (r_captured == 4'hF) begin
                    w_launch     = 1'b1;
                    w_state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (i_frame_ready)
                    w_state_next = ST_COLLECT;
            end
            default: w_state_next = ST_COLLECT;
        endcase
    end

    // A launch clears the accumulator before this cycle's capture lands in the new frame.
    always_comb begin
        w_dec           = decode(r_seg_q);
        w_digit_next    = r_digit;
        w_captured_next = w_launch ? 4'h0 : r_captured;
        w_err_acc_next  = w_launch ? 1'b0 : r_err_acc;
        if (r_cap) begin
            w_err_acc_next = w_err_acc_next | w_dec[4];
            case (r_sel_q)
                4'b1110: begin w_digit_next[3:0]   = w_dec[3:0]; w_captured_next[0] = 1'b1; end
                4'b1101: begin w_digit_next[7:4]   = w_dec[3:0]; w_captured_next[1] = 1'b1; end
                4'b1011: begin w_digit_next[11:8]  = w_dec[3:0]; w_captured_next[2] = 1'b1; end
                4'b0111: begin w_digit_next[15:12] = w_dec[3:0]; w_captured_next[3] = 1'b1; end
                default: w_err_acc_next = w_err_acc_next;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_COLLECT;
            r_seg_q     <= 8'hFF;
            r_sel_q     <= 4'hF;
            r_cnt       <= 8'd0;
            r_cap       <= 1'b0;
            r_digit     <= 16'h0000;
            r_captured  <= 4'h0;
            r_err_acc   <= 1'b0;
            o_value     <= 16'h0000;
            o_frame_err <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_seg_q    <= i_seg_in;
            r_sel_q    <= i_dig_sel;
            r_cnt      <= w_cnt_next;
            r_cap      <= w_cap_next;
            r_digit    <= w_digit_next;
            r_captured <= w_captured_next;
            r_err_acc  <= w_err_acc_next;
            if (w_launch) begin
                o_value     <= r_digit;
                o_frame_err <= r_err_acc;
            end
        end
    end

    assign o_frame_valid = (r_state == ST_HOLD);

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed and randomized scan-bus stimulus for seg_scan_decoder, checked against a
// run-length / frame-set reference model.
module tb_seg_scan_decoder;

    localparam int S = 4;

    logic        clk;
    logic        rst_n;
    logic [7:0]  seg_in;
    logic [3:0]  dig_sel;
    logic        frame_ready;
    logic [15:0] value;
    logic        frame_err;
    logic        frame_valid;

    seg_scan_decoder #(.STABLE_CYCLES(S)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_seg_in      (seg_in),
        .i_dig_sel     (dig_sel),
        .o_value       (value),
        .o_frame_err   (frame_err),
        .o_frame_valid (frame_valid),
        .i_frame_ready (frame_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] codes [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    // Reference model state
    logic [3:0]  m_digit [4];
    logic [3:0]  m_capt;
    logic        m_acc;
    logic        m_valid;
    logic [15:0] m_value;
    logic        m_err;
    int          run;
    logic [7:0]  prev_seg;
    logic [3:0]  prev_sel;
    logic        cap_pend;
    logic [7:0]  cap_seg;
    logic [3:0]  cap_sel;

    // Observation helpers
    logic [15:0] last_val;
    logic        last_err;
    int          n_acc;
    int          vcount;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_digit[i] = 4'h0;
        m_capt = 4'h0; m_acc = 1'b0; m_valid = 1'b0; m_value = 16'h0; m_err = 1'b0;
        run = 0; prev_seg = 8'hFF; prev_sel = 4'hF; cap_pend = 1'b0;
        cap_seg = 8'hFF; cap_sel = 4'hF;
    endtask

    task automatic model_edge();
        int idx;
        int nib;
        int zeros;
        if (m_valid) begin
            if (frame_ready) m_valid = 1'b0;
        end else if (m_capt == 4'hF) begin
            m_valid = 1'b1;
            m_value = {m_digit[3], m_digit[2], m_digit[1], m_digit[0]};
            m_err   = m_acc;
            m_capt  = 4'h0;
            m_acc   = 1'b0;
        end
        if (cap_pend) begin
            idx = 0;
            for (int i = 0; i < 4; i++) if (!cap_sel[i]) idx = i;
            nib = -1;
            for (int c = 0; c < 16; c++) if (codes[c] == cap_seg) nib = c;
            m_digit[idx] = (nib < 0) ? 4'h0 : 4'(nib);
            m_capt[idx]  = 1'b1;
            if (nib < 0) m_acc = 1'b1;
        end
        zeros = 0;
        for (int i = 0; i < 4; i++) if (!dig_sel[i]) zeros++;
        if (zeros != 1)
            run = 0;
        else if (seg_in == prev_seg && dig_sel == prev_sel)
            run++;
        else
            run = 1;
        prev_seg = seg_in; prev_sel = dig_sel;
        cap_pend = (run == S);
        cap_seg  = seg_in; cap_sel = dig_sel;
    endtask

    task automatic tick();
        if (rst_n && frame_valid && frame_ready) begin
            last_val = value; last_err = frame_err; n_acc++;
        end
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
        if (frame_valid) vcount++;
        check("model_valid", 32'(frame_valid), 32'(m_valid));
        check("model_value", 32'(value), 32'(m_value));
        check("model_err", 32'(frame_err), 32'(m_err));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_value", 32'(value), 32'h0);
        check("rst_valid", 32'(frame_valid), 32'h0);
        check("rst_err", 32'(frame_err), 32'h0);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic show(input int idx, input logic [7:0] seg, input int n);
        dig_sel = ~(4'b0001 << idx);
        seg_in  = seg;
        repeat (n) tick();
    endtask

    task automatic blank(input int n);
        dig_sel = 4'hF;
        seg_in  = 8'hFF;
        repeat (n) tick();
    endtask

    task automatic scan(input logic [7:0] d0, input logic [7:0] d1,
                        input logic [7:0] d2, input logic [7:0] d3);
        show(0, d0, 8); show(1, d1, 8); show(2, d2, 8); show(3, d3, 8);
    endtask

    initial begin
        int base;
        rst_n = 1'b1; seg_in = 8'hFF; dig_sel = 4'hF; frame_ready = 1'b0;
        n_acc = 0; vcount = 0; last_val = 16'h0; last_err = 1'b0;
        do_reset();

        // "12AF", ready held high: one single-cycle frame
        frame_ready = 1'b1;
        vcount = 0; base = n_acc;
        scan(8'h8E, 8'h88, 8'hA4, 8'hF9);
        blank(6);
        check("12AF_value", 32'(last_val), 32'h12AF);
        check("12AF_err", 32'(last_err), 32'h0);
        check("12AF_valid_cycles", 32'(vcount), 32'd1);
        check("12AF_accepts", 32'(n_acc - base), 32'd1);

        // Stability threshold: 3 clocks is a glitch, 4 clocks captures
        do_reset();
        frame_ready = 1'b1;
        show(1, 8'hC0, 8); show(2, 8'hC0, 8); show(3, 8'hC0, 8);
        vcount = 0;
        show(0, 8'hC0, 3);
        blank(6);
        check("glitch_no_frame", 32'(vcount), 32'd0);
        show(0, 8'hC0, 4);
        blank(6);
        check("hold4_frame", 32'(vcount), 32'd1);

        // Dash on digit 2 flags the frame; the following clean frame does not
        scan(8'hC0, 8'hC0, 8'hBF, 8'hC0);
        blank(4);
        check("dash_value", 32'(last_val), 32'h0000);
        check("dash_err", 32'(last_err), 32'h1);
        scan(8'hC0, 8'hC0, 8'hC0, 8'hC0);
        blank(4);
        check("clean_err", 32'(last_err), 32'h0);

        // Backpressure: second frame accumulates while the first is held
        frame_ready = 1'b0;
        scan(8'h99, 8'hB0, 8'hA4, 8'hF9);
        scan(8'h80, 8'hF8, 8'h82, 8'h92);
        blank(4);
        check("bp_hold_value", 32'(value), 32'h1234);
        check("bp_hold_valid", 32'(frame_valid), 32'h1);
        frame_ready = 1'b1;
        tick();
        check("bp_drop_valid", 32'(frame_valid), 32'h0);
        tick();
        check("bp_next_value", 32'(value), 32'h5678);
        check("bp_next_valid", 32'(frame_valid), 32'h1);
        blank(2);

        // Invalid selects never capture
        vcount = 0;
        dig_sel = 4'b1100; seg_in = 8'hF9; repeat (12) tick();
        dig_sel = 4'hF;    seg_in = 8'hF9; repeat (12) tick();
        dig_sel = 4'h0;    seg_in = 8'hC0; repeat (12) tick();
        check("badsel_no_frame", 32'(vcount), 32'd0);

        // Reset mid-frame discards the partial frame
        show(0, 8'hF9, 8); show(1, 8'hF9, 8);
        do_reset();
        base = n_acc;
        frame_ready = 1'b1;
        scan(8'hC6, 8'hB0, 8'h86, 8'h90);
        blank(4);
        check("rst_mid_value", 32'(last_val), 32'h9E3C);
        check("rst_mid_err", 32'(last_err), 32'h0);
        check("rst_mid_accepts", 32'(n_acc - base), 32'd1);

        // Randomized scanning with random ready and occasional bad patterns/selects
        for (int ep = 0; ep < 300; ep++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r == 0) begin
                dig_sel = 4'($urandom_range(0, 15));
            end else begin
                dig_sel = ~(4'b0001 << $urandom_range(0, 3));
            end
            if ($urandom_range(0, 6) == 0)
                seg_in = 8'($urandom_range(0, 255));
            else
                seg_in = codes[$urandom_range(0, 15)];
            frame_ready = ($urandom_range(0, 3) != 0);
            repeat ($urandom_range(1, 8)) tick();
        end
        frame_ready = 1'b1;
        blank(6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_decoder.md
# seg_scan_decoder

Receive-side counterpart of the team's hex-to-seven-segment encoder: watches a multiplexed, active-low 4-digit seven-segment scan bus (segment lines plus digit selects), recovers the hex nibble shown on each digit, and presents each complete 4-digit frame as a 16-bit value over a valid/ready handshake. It sits on the board-test and self-check path, reading back what the display drivers emit so adder results can be compared without a camera. Patterns outside the encoder's 16-entry code set are flagged as errors.

## Interface

- STABLE_CYCLES, 4, consecutive identical clocks required before a digit is accepted (1..255).
- Clk  input  1  system clock, rising-edge.
- Reset_n  input  1  asynchronous, active-low reset.
- SegIn  input  8  segment pattern, active-low, bit7 = dp, bits 6:0 = g..a (encoder code set).
- DigSel  input  4  digit anode select, active-low; DigSel[i] low = digit i; digit 0 -> Value[3:0].
- Value  output  16  recovered frame, digit i in Value[4i+3:4i].
- FrameErr  output  1  at least one digit of Value came from an unrecognized pattern.
- FrameValid  output  1  Value/FrameErr hold a frame not yet accepted.
- FrameReady  input  1  consumer accepts the frame on a cycle where FrameValid && FrameReady.

## Operation

- Input stage: SegIn/DigSel registered once (SegQ/SelQ) every clock; no other synchronizer.
- Stability counter (8 bits, saturating at STABLE_CYCLES): loads 1 when SelQ is one-hot-low and {SegQ,SelQ} differs from the previous cycle's value; increments while unchanged and one-hot-low; forced to 0 when SelQ is not one-hot-low (0000, 1111, two lows).
- Capture: one pulse per stable episode, in the cycle the counter reaches STABLE_CYCLES; no re-capture until the inputs change.
- Decode (exact 8-bit match): 0xC0->0, F9->1, A4->2, B0->3, 99->4, 92->5, 82->6, F8->7, 80->8, 90->9, 88->A, 83->B, C6->C, A1->D, 86->E, 8E->F. Any other pattern (dash 0xBF, dp lit, blank 0xFF) -> nibble 0 and error.
- On capture: Digit[idx] <= nibble; Captured[idx] <= 1; ErrAcc <= ErrAcc | error. Re-capture of an already-captured digit overwrites nibble; error accumulation stays sticky.
- States: COLLECT (FrameValid=0) and HOLD (FrameValid=1).
  - COLLECT -> HOLD when registered Captured == 4'hF: Value <= Digit, FrameErr <= ErrAcc, Captured/ErrAcc cleared.
  - HOLD -> COLLECT on FrameValid && FrameReady.
  - In HOLD, captures keep accumulating into the next frame; Value/FrameErr frozen.
- Simultaneous launch and capture: the clear applies first, then that cycle's capture sets its bit/error into the new frame.
- FrameReady ignored in COLLECT.

## Timing

- Reset (async assert, sync release): Value=0, FrameErr=0, FrameValid=0, counter=0, Captured=0, ErrAcc=0, Digit=0, SegQ=0xFF, SelQ=4'hF, state COLLECT.
- Pins changed before edge 0 and held: counter=1 after edge 0; Digit/Captured update at edge STABLE_CYCLES.
- FrameValid rises one edge after the fourth Captured bit sets (edge STABLE_CYCLES+1 for the last digit).
- Handshake: FrameValid falls on the edge after FrameValid && FrameReady; earliest re-assertion is the following edge if Captured is full again (max one frame per two clocks).
- Reset mid-frame: partial frame discarded, no FrameValid until four fresh captures.
- Glitch shorter than STABLE_CYCLES: no capture, no state change.

## Test plan

- Scan "12AF" (DigSel 1110/1101/1011/0111 with 0x8E, 0x88, 0xA4, 0xF9), 8 clocks per digit, FrameReady=1 -> Value=16'h12AF, FrameErr=0, FrameValid high exactly 1 cycle.
- STABLE_CYCLES=4, digit held 3 clocks then switched -> no capture; held 4 -> capture at edge 4.
- Digit 2 shows 0xBF (dash), others valid "0000" -> Value=16'h0000, FrameErr=1; next clean frame FrameErr=0.
- FrameReady=0 for 40 clocks while scan continues "1234" then "5678" -> Value stays 16'h1234; after ready pulse, next Value=16'h5678.
- DigSel=4'b1100 or 4'hF with valid segments -> no captures, FrameValid stays 0.
- Reset_n low after two digits captured, then full "9E3C" scan -> first Value=16'h9E3C, no stale digits.
